// File: rtl/uart_echo_core.sv
// UART transceiver: baud tick, 16x RX, TX, RX->TX FIFO.
// Ports: clk/rst, rxd/txd line, echo_en, host tx_data/tx_wr,
// rx_data/rx_valid/rx_err, fifo_count/fifo_full, ovf/ovf_clr,
// send_over.
module uart_echo_core #(
  parameter int CLK_HZ     = 59000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 16,
  parameter int AW         = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic                 txd,
  input  logic                 echo_en,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_wr,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic [1:0]           rx_err,
  output logic [AW:0]          fifo_count,
  output logic                 fifo_full,
  output logic                 ovf,
  input  logic                 ovf_clr,
  output logic                 send_over
);

  localparam int DIV_RAW = (CLK_HZ + 8*BAUD) / (16*BAUD);
  localparam int DIV = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TMAX = CW'(DIV-1);
  localparam logic [3:0] LAST = 4'(DATA_BITS-1);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP
  } rx_st_t;
  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP
  } tx_st_t;

  function automatic logic f_par(
    input logic [DATA_BITS-1:0] d
  );
    return (PARITY == 1) ? ~^d : ^d;
  endfunction

  // baud tick
  logic [CW-1:0] r_tcnt;
  logic          w_tick;
  assign w_tick = (r_tcnt == TMAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_tcnt <= '0;
    else if (w_tick) r_tcnt <= '0;
    else             r_tcnt <= r_tcnt + CW'(1);
  end

  // receiver
  rx_st_t               r_rx_st, w_rx_nxt;
  logic                 r_rx_s1, r_rx_s2, r_rx_wait;
  logic [3:0]           r_rx_os, w_rx_os_n;
  logic [3:0]           r_rx_bit, w_rx_bit_n;
  logic [DATA_BITS-1:0] r_rx_sh, w_rx_sh_n;
  logic                 r_rx_par, w_rx_par_n;
  logic                 w_rx_done, w_perr;
  logic                 r_rx_valid;
  logic [1:0]           r_rx_err;
  logic [DATA_BITS-1:0] r_rx_data;

  assign w_perr = (PARITY != 0) &&
                  (r_rx_par != f_par(r_rx_sh));

  always_comb begin
    w_rx_nxt   = r_rx_st;
    w_rx_os_n  = r_rx_os;
    w_rx_bit_n = r_rx_bit;
    w_rx_sh_n  = r_rx_sh;
    w_rx_par_n = r_rx_par;
    w_rx_done  = 1'b0;
    if (w_tick) begin
      unique case (r_rx_st)
        RX_IDLE: begin
          if (!r_rx_s2 && !r_rx_wait) begin
            w_rx_nxt  = RX_START;
            w_rx_os_n = '0;
          end
        end
        RX_START: begin
          if (r_rx_os == 4'd7) begin
            w_rx_os_n  = '0;
            w_rx_bit_n = '0;
            w_rx_nxt   = r_rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            w_rx_os_n = r_rx_os + 4'd1;
          end
        end
        RX_DATA: begin
          if (r_rx_os == 4'd15) begin
            w_rx_os_n = '0;
            w_rx_sh_n = {r_rx_s2,
                         r_rx_sh[DATA_BITS-1:1]};
            if (r_rx_bit == LAST) begin
              w_rx_bit_n = '0;
              w_rx_nxt = (PARITY == 0) ?
                         RX_STOP : RX_PAR;
            end else begin
              w_rx_bit_n = r_rx_bit + 4'd1;
            end
          end else begin
            w_rx_os_n = r_rx_os + 4'd1;
          end
        end
        RX_PAR: begin
          if (r_rx_os == 4'd15) begin
            w_rx_os_n  = '0;
            w_rx_par_n = r_rx_s2;
            w_rx_nxt   = RX_STOP;
          end else begin
            w_rx_os_n = r_rx_os + 4'd1;
          end
        end
        RX_STOP: begin
          if (r_rx_os == 4'd15) begin
            w_rx_os_n = '0;
            w_rx_done = 1'b1;
            w_rx_nxt  = RX_IDLE;
          end else begin
            w_rx_os_n = r_rx_os + 4'd1;
          end
        end
        default: w_rx_nxt = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_st    <= RX_IDLE;
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_wait  <= 1'b0;
      r_rx_os    <= '0;
      r_rx_bit   <= '0;
      r_rx_sh    <= '0;
      r_rx_par   <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_err   <= '0;
      r_rx_data  <= '0;
    end else begin
      r_rx_st    <= w_rx_nxt;
      r_rx_s1    <= rxd;
      r_rx_s2    <= r_rx_s1;
      r_rx_os    <= w_rx_os_n;
      r_rx_bit   <= w_rx_bit_n;
      r_rx_sh    <= w_rx_sh_n;
      r_rx_par   <= w_rx_par_n;
      r_rx_valid <= w_rx_done;
      // a low stop bit blocks start detection
      // until the line has returned high
      if (w_rx_done && !r_rx_s2) r_rx_wait <= 1'b1;
      else if (r_rx_s2)          r_rx_wait <= 1'b0;
      if (w_rx_done) begin
        r_rx_data <= r_rx_sh;
        r_rx_err  <= {~r_rx_s2, w_perr};
      end
    end
  end

  // fifo
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wp, r_rp;
  logic [AW:0]          r_cnt;
  logic                 r_ovf;
  logic                 w_pop, w_full;
  logic                 w_wr_req, w_wr_ok, w_ovf_set;
  logic [DATA_BITS-1:0] w_wr_data, w_rd_data;

  assign w_wr_req  = echo_en ?
                     (r_rx_valid && (r_rx_err == 2'b00)) :
                     tx_wr;
  assign w_wr_data = echo_en ? r_rx_data : tx_data;
  assign w_full    = (r_cnt == DEPTH);
  // a pop in the same cycle frees the slot
  assign w_wr_ok   = w_wr_req && (!w_full || w_pop);
  assign w_ovf_set = w_wr_req && w_full && !w_pop;
  assign w_rd_data = r_mem[r_rp];

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wp] <= w_wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr_ok) r_wp <= r_wp + AW'(1);
      if (w_pop)   r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + {{AW{1'b0}}, w_wr_ok}
                     - {{AW{1'b0}}, w_pop};
      if (w_ovf_set)    r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end

  // transmitter
  tx_st_t               r_tx_st, w_tx_nxt;
  logic                 r_txd, w_txd_n;
  logic [3:0]           r_tx_os, w_tx_os_n;
  logic [3:0]           r_tx_bit, w_tx_bit_n;
  logic [DATA_BITS-1:0] r_tx_sh, w_tx_sh_n;
  logic                 r_tx_par, w_tx_par_n;
  logic                 w_tx_done, r_send_over;

  always_comb begin
    w_tx_nxt   = r_tx_st;
    w_txd_n    = r_txd;
    w_tx_os_n  = r_tx_os;
    w_tx_bit_n = r_tx_bit;
    w_tx_sh_n  = r_tx_sh;
    w_tx_par_n = r_tx_par;
    w_pop      = 1'b0;
    w_tx_done  = 1'b0;
    unique case (r_tx_st)
      TX_IDLE: begin
        if (r_cnt != '0) begin
          w_pop      = 1'b1;
          w_tx_sh_n  = w_rd_data;
          w_tx_par_n = f_par(w_rd_data);
          w_tx_os_n  = '0;
          w_tx_bit_n = '0;
          w_tx_nxt   = TX_START;
        end
      end
      TX_START: begin
        // txd still high: this tick opens the start bit
        if (w_tick) begin
          if (r_txd) begin
            w_txd_n = 1'b0;
          end else if (r_tx_os == 4'd15) begin
            w_tx_os_n = '0;
            w_txd_n   = r_tx_sh[0];
            w_tx_nxt  = TX_DATA;
          end else begin
            w_tx_os_n = r_tx_os + 4'd1;
          end
        end
      end
      TX_DATA: begin
        if (w_tick) begin
          if (r_tx_os == 4'd15) begin
            w_tx_os_n = '0;
            if (r_tx_bit == LAST) begin
              w_tx_bit_n = '0;
              w_tx_nxt = (PARITY == 0) ?
                         TX_STOP : TX_PAR;
              w_txd_n  = (PARITY == 0) ?
                         1'b1 : r_tx_par;
            end else begin
              w_tx_bit_n = r_tx_bit + 4'd1;
              w_tx_sh_n  = {1'b0,
                            r_tx_sh[DATA_BITS-1:1]};
              w_txd_n    = r_tx_sh[1];
            end
          end else begin
            w_tx_os_n = r_tx_os + 4'd1;
          end
        end
      end
      TX_PAR: begin
        if (w_tick) begin
          if (r_tx_os == 4'd15) begin
            w_tx_os_n = '0;
            w_txd_n   = 1'b1;
            w_tx_nxt  = TX_STOP;
          end else begin
            w_tx_os_n = r_tx_os + 4'd1;
          end
        end
      end
      TX_STOP: begin
        if (w_tick) begin
          if (r_tx_os == 4'd15) begin
            w_tx_os_n = '0;
            w_tx_done = 1'b1;
            w_tx_nxt  = TX_IDLE;
          end else begin
            w_tx_os_n = r_tx_os + 4'd1;
          end
        end
      end
      default: begin
        w_tx_nxt = TX_IDLE;
        w_txd_n  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_st     <= TX_IDLE;
      r_txd       <= 1'b1;
      r_tx_os     <= '0;
      r_tx_bit    <= '0;
      r_tx_sh     <= '0;
      r_tx_par    <= 1'b0;
      r_send_over <= 1'b0;
    end else begin
      r_tx_st     <= w_tx_nxt;
      r_txd       <= w_txd_n;
      r_tx_os     <= w_tx_os_n;
      r_tx_bit    <= w_tx_bit_n;
      r_tx_sh     <= w_tx_sh_n;
      r_tx_par    <= w_tx_par_n;
      r_send_over <= w_tx_done;
    end
  end

  assign txd        = r_txd;
  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign rx_err     = r_rx_err;
  assign fifo_count = r_cnt;
  assign fifo_full  = w_full;
  assign ovf        = r_ovf;
  assign send_over  = r_send_over;

endmodule

// File: tb/tb_uart_echo_core.sv
// Bench for uart_echo_core: scoreboard queues for RX and TX,
// random frames, echo/host modes, overflow and reset cases.
module tb_uart_echo_core;

  localparam int PAR = 2;
  localparam int BIT = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       txd;
  logic       echo_en;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [1:0] rx_err;
  logic [4:0] fifo_count;
  logic       fifo_full;
  logic       ovf;
  logic       ovf_clr;
  logic       send_over;

  int n_cmp = 0;
  int n_bad = 0;
  int so_cnt = 0;
  int frames_ok = 0;
  bit tx_abort = 1'b0;

  logic [7:0] tx_q[$];
  logic [9:0] rx_q[$];

  uart_echo_core #(
    .CLK_HZ(3200000), .BAUD(100000), .DATA_BITS(8),
    .PARITY(PAR), .FIFO_DEPTH(16), .AW(4)
  ) u_dut (
    .clk(clk), .rst(rst), .rxd(rxd), .txd(txd),
    .echo_en(echo_en), .tx_data(tx_data),
    .tx_wr(tx_wr), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_err(rx_err),
    .fifo_count(fifo_count), .fifo_full(fifo_full),
    .ovf(ovf), .ovf_clr(ovf_clr),
    .send_over(send_over)
  );

  always #5 clk = ~clk;

  function automatic logic par_of(input logic [7:0] d);
    return (PAR == 1) ? ~^d : ^d;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  // TX line monitor: decode frames at bit centres
  initial begin : tx_mon
    logic [10:0] got;
    logic [10:0] exp;
    logic [7:0]  d;
    bit          found;
    forever begin
      @(negedge clk);
      if (rst && !txd) begin
        repeat (BIT/2 - 1) @(negedge clk);
        got[0] = txd;
        for (int b = 1; b < 11; b++) begin
          repeat (BIT) @(negedge clk);
          got[b] = txd;
        end
        if (tx_abort) begin
          tx_abort = 1'b0;
        end else begin
          if (tx_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL tx_unexp: got frame %h want none",
                     got);
          end else begin
            d = tx_q.pop_front();
            exp = {1'b1, par_of(d), d, 1'b0};
            chk("tx_frame", {21'd0, got}, {21'd0, exp});
          end
          found = 1'b0;
          for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (send_over) found = 1'b1;
          end
          chk("send_over", {31'd0, found}, 32'd1);
          frames_ok++;
        end
      end
    end
  end

  // RX output monitor
  always @(negedge clk) begin
    if (rst && rx_valid) begin
      if (rx_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rx_unexp: got %h/%h want none",
                 rx_err, rx_data);
      end else begin
        chk("rx_char", {22'd0, rx_err, rx_data},
            {22'd0, rx_q.pop_front()});
      end
    end
  end

  always @(negedge clk) if (send_over) so_cnt++;

  task automatic host_wr(input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    tx_wr = 1'b1;
    @(negedge clk);
    tx_wr = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] d,
                         input bit bp, input bit bs);
    logic [10:0] f;
    f = {~bs, par_of(d) ^ bp, d, 1'b0};
    rx_q.push_back({bs, bp, d});
    if (echo_en && !bs && !bp) tx_q.push_back(d);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      rxd = f[i];
      repeat (BIT - 1) @(negedge clk);
    end
    @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  task automatic drain(input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (tx_q.size() == 0 && rx_q.size() == 0 &&
          fifo_count == 5'd0) break;
    end
    repeat (40) @(negedge clk);
    chk("drain_txq", tx_q.size(), 0);
    chk("drain_rxq", rx_q.size(), 0);
    chk("fifo_idle", {27'd0, fifo_count}, 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0] d;
    int kind;
    int so_before;
    rst = 1'b0;
    rxd = 1'b1;
    echo_en = 1'b0;
    tx_data = '0;
    tx_wr = 1'b0;
    ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_txd", {31'd0, txd}, 1);
    chk("rst_rx_valid", {31'd0, rx_valid}, 0);
    chk("rst_rx_err", {30'd0, rx_err}, 0);
    chk("rst_rx_data", {24'd0, rx_data}, 0);
    chk("rst_count", {27'd0, fifo_count}, 0);
    chk("rst_ovf", {31'd0, ovf}, 0);
    chk("rst_send_over", {31'd0, send_over}, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // host mode
    tx_q.push_back(8'hA5);
    host_wr(8'hA5);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      d = 8'($urandom);
      tx_q.push_back(d);
      host_wr(d);
    end
    drain(4000);

    // echo mode
    echo_en = 1'b1;
    send_rx(8'h3C, 1'b0, 1'b0);
    send_rx(8'h5A, 1'b1, 1'b0);
    chk("fifo_after_perr", {27'd0, fifo_count}, 0);
    send_rx(8'h81, 1'b0, 1'b1);
    chk("fifo_after_ferr", {27'd0, fifo_count}, 0);
    host_wr(8'($urandom));
    for (int i = 0; i < 8; i++) begin
      kind = $urandom_range(0, 3);
      send_rx(8'($urandom), kind[0], kind[1]);
    end
    drain(4000);

    // glitch then a good frame
    @(negedge clk);
    rxd = 1'b0;
    repeat (6) @(negedge clk);
    rxd = 1'b1;
    repeat (100) @(negedge clk);
    send_rx(8'($urandom), 1'b0, 1'b0);
    drain(2000);

    // overflow in host mode
    echo_en = 1'b0;
    d = 8'($urandom);
    tx_q.push_back(d);
    host_wr(d);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      d = 8'($urandom);
      tx_data = d;
      tx_wr = 1'b1;
      if (i < 16) tx_q.push_back(d);
    end
    @(negedge clk);
    tx_wr = 1'b0;
    chk("ovf_count", {27'd0, fifo_count}, 16);
    chk("ovf_full", {31'd0, fifo_full}, 1);
    chk("ovf_set", {31'd0, ovf}, 1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovf_clr", {31'd0, ovf}, 0);
    ovf_clr = 1'b1;
    tx_wr = 1'b1;
    tx_data = 8'($urandom);
    @(negedge clk);
    ovf_clr = 1'b0;
    tx_wr = 1'b0;
    chk("ovf_set_wins", {31'd0, ovf}, 1);
    chk("ovf_count2", {27'd0, fifo_count}, 16);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovf_clr2", {31'd0, ovf}, 0);
    drain(9000);

    // reset mid-transmit
    host_wr(8'($urandom));
    repeat (3) @(negedge clk);
    host_wr(8'($urandom));
    repeat (120) @(negedge clk);
    tx_abort = 1'b1;
    so_before = so_cnt;
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_txd", {31'd0, txd}, 1);
    chk("rst_mid_count", {27'd0, fifo_count}, 0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (500) @(negedge clk);
    chk("rst_no_send_over", so_cnt, so_before);
    chk("rst_txd_idle", {31'd0, txd}, 1);
    chk("rst_count_after", {27'd0, fifo_count}, 0);

    chk("so_total", so_cnt, frames_ok);
    chk("end_txq", tx_q.size(), 0);
    chk("end_rxq", rx_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
